// File: rtl/en_tick_gen_pkg.sv
// en_tick_gen_pkg
//   Shared definitions for the clock-enable strobe generator.
//   - state_t : FSM state encoding (IDLE/RUN/SINGLE); 2'd3 is unused and
//               is steered back to IDLE by the FSM default branch.
//   - default widths for the period counter and the tick counter.
package en_tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SINGLE = 2'd2
    } state_t;

    localparam int CNT_W_DEF  = 4;
    localparam int TICK_W_DEF = 8;

endpackage

// File: rtl/en_tick_gen_mod_down_counter.sv
// mod_down_counter
//   Loadable down-counter used to time the gap between enable strobes.
//   Ports:
//     clk, reset  : system clock, synchronous active-high reset (cnt -> 0)
//     load        : load load_val this edge (takes priority over dec)
//     dec         : decrement by one this edge
//     load_val    : value loaded on load
//     zero        : count currently equals zero
module mod_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/en_tick_gen.sv
// en_tick_gen
//   Programmable clock-enable strobe generator. Emits a one-cycle en pulse
//   every P clocks in continuous mode, or a single pulse on request.
//   Ports:
//     clk, reset  : system clock, synchronous active-high reset
//     start       : enter continuous mode (accepted in IDLE only)
//     stop        : return to IDLE from RUN/SINGLE, suppressing any pulse due
//     single      : request one pulse (accepted in IDLE only, start wins)
//     period      : strobe period, 0 treated as 1, latched on accept
//     en          : registered one-cycle enable strobe
//     busy        : high while not IDLE
//     tick_count  : pulses issued since reset, wraps
module en_tick_gen
    import en_tick_gen_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              single,
    input  logic [CNT_W-1:0]  period,
    output logic              en,
    output logic              busy,
    output logic [TICK_W-1:0] tick_count
);

    state_t             state;
    logic [CNT_W-1:0]   p_q;
    logic [CNT_W-1:0]   p_eff;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;

    // A zero period would never fire; run it as period 1.
    assign p_eff = (period == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : period;

    // Counter control: reload on accept and on every expiry, otherwise count
    // down. stop freezes the counter; its value is reloaded on the next accept.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = p_eff - 1'b1;
        case (state)
            ST_IDLE: begin
                if (start || single)
                    cnt_load = 1'b1;
            end
            ST_RUN, ST_SINGLE: begin
                if (!stop) begin
                    if (cnt_zero) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = p_q - 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    mod_down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            p_q        <= {{(CNT_W-1){1'b0}}, 1'b1};
            en         <= 1'b0;
            tick_count <= '0;
        end else begin
            en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        p_q   <= p_eff;
                    end else if (single) begin
                        state <= ST_SINGLE;
                        p_q   <= p_eff;
                    end
                end
                ST_RUN, ST_SINGLE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (cnt_zero) begin
                        en         <= 1'b1;
                        tick_count <= tick_count + 1'b1;
                        // single-shot drops busy on the same edge en rises
                        if (state == ST_SINGLE)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
